// File: rtl/native_ext_bridge.sv
// Terminating reg_native_if responder: range-checks a forwarded request, converts it to a
// window offset and runs one access on an external variable-latency register bus.
module native_ext_bridge #(
  parameter int unsigned           ADDR_WIDTH     = 48,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           EXT_ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 'h20000000,
  parameter int unsigned           TIMEOUT_CYCLES = 256
) (
  input  logic                      native_ext_bridge_clk,
  input  logic                      native_ext_bridge_rst,
  input  logic                      upstream__native_ext_bridge__req_vld,
  input  logic [ADDR_WIDTH-1:0]     upstream__native_ext_bridge__addr,
  input  logic                      upstream__native_ext_bridge__wr_en,
  input  logic                      upstream__native_ext_bridge__rd_en,
  input  logic [DATA_WIDTH-1:0]     upstream__native_ext_bridge__wr_data,
  input  logic                      upstream__native_ext_bridge__soft_rst,
  output logic                      native_ext_bridge__upstream__ack_vld,
  output logic                      native_ext_bridge__upstream__err,
  output logic [DATA_WIDTH-1:0]     native_ext_bridge__upstream__rd_data,
  output logic                      native_ext_bridge__ext__req,
  output logic [EXT_ADDR_WIDTH-1:0] native_ext_bridge__ext__addr,
  output logic                      native_ext_bridge__ext__wr_en,
  output logic                      native_ext_bridge__ext__rd_en,
  output logic [DATA_WIDTH-1:0]     native_ext_bridge__ext__wr_data,
  output logic                      native_ext_bridge__ext__soft_rst,
  input  logic                      ext__native_ext_bridge__ack,
  input  logic                      ext__native_ext_bridge__err,
  input  logic [DATA_WIDTH-1:0]     ext__native_ext_bridge__rd_data
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast =
      CntW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  // One extra bit so the window limit cannot wrap at the top of the address space.
  localparam logic [ADDR_WIDTH:0] WinLo = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0] WinHi = WinLo + ((ADDR_WIDTH + 1)'(1) << EXT_ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] AlignMask = ADDR_WIDTH'(DATA_WIDTH / 8 - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StErr, StResp} state_e;

  state_e                    state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      ext_req_q, ext_req_d;
  logic [EXT_ADDR_WIDTH-1:0] ext_addr_q, ext_addr_d;
  logic                      ext_wr_q, ext_wr_d;
  logic                      ext_rd_q, ext_rd_d;
  logic [DATA_WIDTH-1:0]     ext_wdata_q, ext_wdata_d;
  logic                      ext_srst_q, ext_srst_d;
  logic                      ack_q, ack_d;
  logic                      err_q, err_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;

  logic                      in_win;
  logic                      aligned;
  logic                      req_legal;
  logic [EXT_ADDR_WIDTH-1:0] offset;

  assign in_win    = ({1'b0, upstream__native_ext_bridge__addr} >= WinLo) &&
                     ({1'b0, upstream__native_ext_bridge__addr} < WinHi);
  assign aligned   = (upstream__native_ext_bridge__addr & AlignMask) == '0;
  assign req_legal = in_win && aligned &&
                     (upstream__native_ext_bridge__wr_en ^ upstream__native_ext_bridge__rd_en);
  // Modular subtraction on the low bits equals the truncated full-width difference.
  assign offset    = upstream__native_ext_bridge__addr[EXT_ADDR_WIDTH-1:0] -
                     BASE_ADDR[EXT_ADDR_WIDTH-1:0];

  always_ff @(posedge native_ext_bridge_clk) begin
    if (native_ext_bridge_rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ext_req_q   <= 1'b0;
      ext_addr_q  <= '0;
      ext_wr_q    <= 1'b0;
      ext_rd_q    <= 1'b0;
      ext_wdata_q <= '0;
      ext_srst_q  <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ext_req_q   <= ext_req_d;
      ext_addr_q  <= ext_addr_d;
      ext_wr_q    <= ext_wr_d;
      ext_rd_q    <= ext_rd_d;
      ext_wdata_q <= ext_wdata_d;
      ext_srst_q  <= ext_srst_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    ext_req_d   = 1'b0;
    ext_addr_d  = '0;
    ext_wr_d    = 1'b0;
    ext_rd_d    = 1'b0;
    ext_wdata_d = '0;
    ext_srst_d  = upstream__native_ext_bridge__soft_rst;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    rdata_d     = '0;

    unique case (state_q)
      StIdle: begin
        if (upstream__native_ext_bridge__req_vld) begin
          if (req_legal) begin
            state_d     = StAccess;
            ext_req_d   = 1'b1;
            ext_addr_d  = offset;
            ext_wr_d    = upstream__native_ext_bridge__wr_en;
            ext_rd_d    = upstream__native_ext_bridge__rd_en;
            ext_wdata_d = upstream__native_ext_bridge__wr_data;
          end else begin
            state_d = StErr;
          end
        end
      end
      StAccess: begin
        if (ext__native_ext_bridge__ack) begin
          state_d = StResp;
          ack_d   = 1'b1;
          err_d   = ext__native_ext_bridge__err;
          rdata_d = ext_rd_q ? ext__native_ext_bridge__rd_data : '0;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CntLast)) begin
          state_d = StResp;
          ack_d   = 1'b1;
          err_d   = 1'b1;
        end else begin
          ext_req_d   = 1'b1;
          ext_addr_d  = ext_addr_q;
          ext_wr_d    = ext_wr_q;
          ext_rd_d    = ext_rd_q;
          ext_wdata_d = ext_wdata_q;
          cnt_d       = cnt_q + CntW'(1);
        end
      end
      StErr: begin
        state_d = StResp;
        ack_d   = 1'b1;
        err_d   = 1'b1;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Soft reset drops everything, including an in-flight access and its response.
    if (upstream__native_ext_bridge__soft_rst) begin
      state_d     = StIdle;
      cnt_d       = '0;
      ext_req_d   = 1'b0;
      ext_addr_d  = '0;
      ext_wr_d    = 1'b0;
      ext_rd_d    = 1'b0;
      ext_wdata_d = '0;
      ack_d       = 1'b0;
      err_d       = 1'b0;
      rdata_d     = '0;
    end
  end

  always_comb begin
    native_ext_bridge__upstream__ack_vld = ack_q;
    native_ext_bridge__upstream__err     = err_q;
    native_ext_bridge__upstream__rd_data = rdata_q;
    native_ext_bridge__ext__req          = ext_req_q;
    native_ext_bridge__ext__addr         = ext_addr_q;
    native_ext_bridge__ext__wr_en        = ext_wr_q;
    native_ext_bridge__ext__rd_en        = ext_rd_q;
    native_ext_bridge__ext__wr_data      = ext_wdata_q;
    native_ext_bridge__ext__soft_rst     = ext_srst_q;
  end

endmodule

// File: tb/tb_native_ext_bridge.sv
// Self-checking bench for native_ext_bridge: transaction-level expectations derived from the
// window/latency rules, compared against the DUT on every cycle.
module tb_native_ext_bridge;

  localparam longint unsigned BASE = 64'h2000_0000;
  localparam int              TO   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        up_req_vld, up_wr_en, up_rd_en, up_soft_rst;
  logic [47:0] up_addr;
  logic [31:0] up_wr_data;
  logic        ack_vld, up_err;
  logic [31:0] up_rd_data;
  logic        ext_req, ext_wr_en, ext_rd_en, ext_soft_rst;
  logic [11:0] ext_addr;
  logic [31:0] ext_wr_data;
  logic        ext_ack, ext_err;
  logic [31:0] ext_rd_data;

  always #5 clk = ~clk;

  native_ext_bridge #(
    .ADDR_WIDTH    (48),
    .DATA_WIDTH    (32),
    .EXT_ADDR_WIDTH(12),
    .BASE_ADDR     (48'h2000_0000),
    .TIMEOUT_CYCLES(TO)
  ) u_dut (
    .native_ext_bridge_clk                (clk),
    .native_ext_bridge_rst                (rst),
    .upstream__native_ext_bridge__req_vld (up_req_vld),
    .upstream__native_ext_bridge__addr    (up_addr),
    .upstream__native_ext_bridge__wr_en   (up_wr_en),
    .upstream__native_ext_bridge__rd_en   (up_rd_en),
    .upstream__native_ext_bridge__wr_data (up_wr_data),
    .upstream__native_ext_bridge__soft_rst(up_soft_rst),
    .native_ext_bridge__upstream__ack_vld (ack_vld),
    .native_ext_bridge__upstream__err     (up_err),
    .native_ext_bridge__upstream__rd_data (up_rd_data),
    .native_ext_bridge__ext__req          (ext_req),
    .native_ext_bridge__ext__addr         (ext_addr),
    .native_ext_bridge__ext__wr_en        (ext_wr_en),
    .native_ext_bridge__ext__rd_en        (ext_rd_en),
    .native_ext_bridge__ext__wr_data      (ext_wr_data),
    .native_ext_bridge__ext__soft_rst     (ext_soft_rst),
    .ext__native_ext_bridge__ack          (ext_ack),
    .ext__native_ext_bridge__err          (ext_err),
    .ext__native_ext_bridge__rd_data      (ext_rd_data)
  );

  // Expected outputs for the current cycle
  logic        exp_ack, exp_err, exp_req, exp_wr, exp_rd, exp_srst;
  logic [31:0] exp_rdata, exp_wdata;
  logic [11:0] exp_addr;
  bit          chk_en = 1'b0;

  int          checks = 0;
  int          errors = 0;
  int          req_cycles = 0;
  int          ack_count = 0;
  logic [31:0] last_rdata, last_wdata;
  logic        last_err;
  logic [11:0] last_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ack_vld", 64'(ack_vld), 64'(exp_ack));
      chk("err", 64'(up_err), 64'(exp_err));
      chk("rd_data", 64'(up_rd_data), 64'(exp_rdata));
      chk("ext_req", 64'(ext_req), 64'(exp_req));
      chk("ext_soft_rst", 64'(ext_soft_rst), 64'(exp_srst));
      if (exp_req) begin
        chk("ext_addr", 64'(ext_addr), 64'(exp_addr));
        chk("ext_wr_en", 64'(ext_wr_en), 64'(exp_wr));
        chk("ext_rd_en", 64'(ext_rd_en), 64'(exp_rd));
        chk("ext_wr_data", 64'(ext_wr_data), 64'(exp_wdata));
      end
      if (ext_req) begin
        req_cycles++;
        last_addr  = ext_addr;
        last_wdata = ext_wr_data;
      end
      if (ack_vld) begin
        ack_count++;
        last_rdata = up_rd_data;
        last_err   = up_err;
      end
    end
  end

  // Reference rules: window membership, alignment, one-hot access type
  function automatic bit m_legal(input logic [47:0] a, input logic w, input logic r);
    longint unsigned av;
    av = 64'(a);
    return (av >= BASE) && (av < BASE + 4096) && (av % 4 == 0) && (w != r);
  endfunction

  function automatic logic [11:0] m_off(input logic [47:0] a);
    longint unsigned d;
    d = 64'(a) - BASE;
    return d[11:0];
  endfunction

  // Advance one cycle; ext soft_rst must echo the soft_rst sampled at that edge.
  task automatic tick();
    logic sr, rr;
    sr = up_soft_rst;
    rr = rst;
    @(posedge clk);
    #1;
    exp_srst = sr & ~rr;
  endtask

  task automatic clear_exp();
    exp_ack   = 1'b0;
    exp_err   = 1'b0;
    exp_rdata = '0;
    exp_req   = 1'b0;
  endtask

  task automatic junk_ext();
    ext_ack     = ($urandom % 4 == 0);
    ext_err     = 1'($urandom);
    ext_rd_data = $urandom;
  endtask

  task automatic idle_cycle();
    clear_exp();
    up_req_vld  = 1'b0;
    up_soft_rst = ($urandom % 10 == 0);
    junk_ext();
    tick();
  endtask

  task automatic txn(input logic [47:0] a, input logic w, input logic r, input logic [31:0] wd,
                     input int k, input logic eerr, input logic [31:0] erd, input int srst_at,
                     input bit rst_resp);
    bit          legal;
    logic [11:0] off;
    int          last;
    logic [31:0] r1;
    legal = m_legal(a, w, r);
    off   = m_off(a);
    clear_exp();
    up_req_vld  = 1'b1;
    up_addr     = a;
    up_wr_en    = w;
    up_rd_en    = r;
    up_wr_data  = wd;
    up_soft_rst = 1'b0;
    junk_ext();
    tick();
    if (!legal) begin
      clear_exp();
      up_req_vld = 1'b0;
      junk_ext();
      tick();
      exp_ack   = 1'b1;
      exp_err   = 1'b1;
      exp_rdata = '0;
      junk_ext();
    end else begin
      last = (k <= TO) ? k : TO;
      for (int c = 1; c <= last; c++) begin
        clear_exp();
        exp_req   = 1'b1;
        exp_addr  = off;
        exp_wr    = w;
        exp_rd    = r;
        exp_wdata = wd;
        // Upstream noise while busy must be ignored
        r1          = $urandom;
        up_req_vld  = ($urandom % 3 == 0);
        up_addr     = {16'h0, r1};
        up_wr_en    = 1'($urandom);
        up_rd_en    = 1'($urandom);
        up_wr_data  = $urandom;
        up_soft_rst = (c == srst_at);
        ext_ack     = (c == k) && (c != srst_at);
        ext_err     = (c == k) ? eerr : 1'($urandom);
        ext_rd_data = (c == k) ? erd : $urandom;
        tick();
        if (c == srst_at) begin
          clear_exp();
          up_req_vld  = 1'b0;
          up_soft_rst = 1'b0;
          ext_ack     = 1'b1;
          ext_err     = 1'($urandom);
          ext_rd_data = $urandom;
          tick();
          clear_exp();
          ext_ack = 1'b0;
          tick();
          return;
        end
      end
      clear_exp();
      exp_ack     = 1'b1;
      exp_err     = (k <= TO) ? eerr : 1'b1;
      exp_rdata   = (k <= TO && r) ? erd : 32'h0;
      up_req_vld  = 1'b0;
      up_soft_rst = 1'b0;
      ext_ack     = (k == TO + 1);
      ext_err     = 1'($urandom);
      ext_rd_data = $urandom;
    end
    up_req_vld = 1'b0;
    if (rst_resp) begin
      rst = 1'b1;
      tick();
      clear_exp();
      tick();
      rst = 1'b0;
      clear_exp();
      tick();
    end else begin
      tick();
    end
  endtask

  int          rc0, ac0;
  logic [31:0] ra, rb;
  logic [47:0] a;
  logic        w, r;
  int          k, sa, sel;

  initial begin
    rst = 1'b1;
    up_req_vld = 1'b0; up_addr = '0; up_wr_en = 1'b0; up_rd_en = 1'b0;
    up_wr_data = '0; up_soft_rst = 1'b0;
    ext_ack = 1'b0; ext_err = 1'b0; ext_rd_data = '0;
    clear_exp();
    exp_wr = 1'b0; exp_rd = 1'b0; exp_addr = '0; exp_wdata = '0; exp_srst = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    idle_cycle();

    // 1: read, ext ack three cycles after the request
    rc0 = req_cycles; ac0 = ack_count;
    txn(48'h2000_0010, 1'b0, 1'b1, 32'h0, 3, 1'b0, 32'hDEAD_BEEF, 0, 1'b0);
    chk("t1_rdata", 64'(last_rdata), 64'hDEAD_BEEF);
    chk("t1_err", 64'(last_err), 64'h0);
    chk("t1_addr", 64'(last_addr), 64'h010);
    chk("t1_req_cycles", 64'(req_cycles - rc0), 64'd3);
    chk("t1_acks", 64'(ack_count - ac0), 64'd1);

    // 2: write at the top word of the window, immediate ack
    rc0 = req_cycles;
    txn(48'h2000_0FFC, 1'b1, 1'b0, 32'h1234_5678, 1, 1'b0, 32'hFFFF_FFFF, 0, 1'b0);
    chk("t2_addr", 64'(last_addr), 64'hFFC);
    chk("t2_wdata", 64'(last_wdata), 64'h1234_5678);
    chk("t2_rdata", 64'(last_rdata), 64'h0);
    chk("t2_req_cycles", 64'(req_cycles - rc0), 64'd1);

    // 3: out of range, misaligned, ambiguous access type
    rc0 = req_cycles; ac0 = ack_count;
    txn(48'h2000_1000, 1'b0, 1'b1, 32'h0, 1, 1'b0, 32'h0, 0, 1'b0);
    txn(48'h2000_0002, 1'b0, 1'b1, 32'h0, 1, 1'b0, 32'h0, 0, 1'b0);
    txn(48'h2000_0020, 1'b1, 1'b1, 32'h0, 1, 1'b0, 32'h0, 0, 1'b0);
    chk("t3_req_cycles", 64'(req_cycles - rc0), 64'd0);
    chk("t3_acks", 64'(ack_count - ac0), 64'd3);
    chk("t3_err", 64'(last_err), 64'h1);

    // 4: timeout, then ack landing in the final allowed cycle
    rc0 = req_cycles;
    txn(48'h2000_0100, 1'b0, 1'b1, 32'h0, 99, 1'b0, 32'h5555_5555, 0, 1'b0);
    chk("t4_req_cycles", 64'(req_cycles - rc0), 64'd4);
    chk("t4_err", 64'(last_err), 64'h1);
    chk("t4_rdata", 64'(last_rdata), 64'h0);
    txn(48'h2000_0104, 1'b0, 1'b1, 32'h0, 4, 1'b0, 32'hCAFE_F00D, 0, 1'b0);
    chk("t4b_err", 64'(last_err), 64'h0);
    chk("t4b_rdata", 64'(last_rdata), 64'hCAFE_F00D);
    txn(48'h2000_0108, 1'b0, 1'b1, 32'h0, 4, 1'b1, 32'h0BAD_0BAD, 0, 1'b0);
    chk("t4c_err", 64'(last_err), 64'h1);

    // 5: soft reset mid-access drops the response; next read is normal
    ac0 = ack_count;
    txn(48'h2000_0200, 1'b0, 1'b1, 32'h0, 5, 1'b0, 32'h1111_1111, 2, 1'b0);
    chk("t5_no_ack", 64'(ack_count - ac0), 64'd0);
    txn(48'h2000_0204, 1'b0, 1'b1, 32'h0, 2, 1'b0, 32'h2222_2222, 0, 1'b0);
    chk("t5_rdata", 64'(last_rdata), 64'h2222_2222);

    // 6: hard reset held across the response cycle
    txn(48'h2000_0300, 1'b1, 1'b0, 32'hA5A5_A5A5, 2, 1'b0, 32'h0, 0, 1'b1);
    idle_cycle();

    for (int i = 0; i < 300; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom % 10;
      if (sel == 0) begin
        a = 48'(BASE) + 48'(4 * $urandom_range(0, 1023)) + 48'($urandom_range(1, 3));
      end else if (sel == 1) begin
        unique case (rb % 4)
          0:       a = 48'h1FFF_FFFC;
          1:       a = 48'h2000_1000;
          2:       a = 48'h1_2000_0000;
          default: a = {ra[15:0], rb};
        endcase
      end else begin
        a = 48'(BASE) + 48'(4 * $urandom_range(0, 1023));
      end
      if ($urandom % 8 == 0) begin
        w = ra[20];
        r = ra[20];
      end else begin
        w = ra[21];
        r = ~ra[21];
      end
      k  = $urandom_range(1, 6);
      sa = (k >= 2 && $urandom % 12 == 0) ? $urandom_range(1, (k - 1 < TO) ? k - 1 : TO) : 0;
      txn(a, w, r, $urandom, k, ($urandom % 4 == 0), $urandom, sa,
          (sa == 0) && ($urandom % 15 == 0));
      repeat ($urandom % 3) idle_cycle();
    end

    idle_cycle();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
